// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the parametrised SRAM controller.
//   state_t   : controller FSM state encoding
//   clog2     : ceiling log2 for elaboration-time sizing
//   width_of  : counter width able to hold 0..n-1 (never less than 1 bit)
//   BEATS/BEAT_W/CNT_W : derived constants for the default 32-over-16, 3-wait build
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SRAM_DW     = 16;
  localparam int DEF_WAIT_CYCLES = 3;

  localparam int BEATS  = DEF_DATA_W / DEF_SRAM_DW;
  localparam int BEAT_W = width_of(BEATS);
  localparam int CNT_W  = width_of(DEF_WAIT_CYCLES);

endpackage

// File: rtl/sram_dq_io.sv
// Tristate pad driver for the bidirectional SRAM data bus.
//   dq   : SRAM data bus (inout)
//   oe   : drive enable, high drives dout onto dq
//   dout : data to drive
//   din  : current bus value seen by the controller
module sram_dq_io #(
  parameter int W = 16
) (
  inout  wire  [W-1:0] dq,
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din
);

  assign dq  = oe ? dout : {W{1'bz}};
  assign din = dq;

endmodule

// File: rtl/sram_ctrl_param.sv
// Memory-stage SRAM controller: splits one DATA_W load/store into
// DATA_W/SRAM_DW little-endian beats, each held WAIT_CYCLES on the pins,
// and freezes the pipeline until the access completes.
//   clk, rst          : clock, async active-low reset
//   wr_en, rd_en      : store / load request (store wins when both high)
//   addr, wdata       : CPU byte address and store data
//   rdata, ready      : assembled load data, one-cycle completion pulse
//   freeze            : pipeline stall request
//   SRAM_*            : off-chip SRAM pins (controls active-low)
//
// state  | meaning
// IDLE   | waiting for a request; latches op/addr/data on request
// ACCESS | beats in flight on the SRAM pins
// DONE   | one-cycle completion, SRAM deselected, ready high
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  output logic               freeze,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int NBEATS  = DATA_W / SRAM_DW;
  localparam int NBEAT_W = width_of(NBEATS);
  localparam int NCNT_W  = width_of(WAIT_CYCLES);
  localparam int BYTE_SH = clog2(DATA_W / 8);
  localparam logic [31:0] BASE_U  = 32'(BASE_ADDR);
  localparam logic [31:0] BEATS_U = 32'(NBEATS);

  generate
    if ((DATA_W % SRAM_DW) != 0 || DATA_W < SRAM_DW || WAIT_CYCLES < 1) begin : g_bad_param
      $fatal(1, "sram_ctrl_param: DATA_W must be a multiple of SRAM_DW and WAIT_CYCLES >= 1");
    end
  endgenerate

  state_t               state;
  logic [NBEAT_W-1:0]   beat;
  logic [NCNT_W-1:0]    cnt;
  logic                 op_wr;
  logic [SRAM_AW-1:0]   base_q;
  logic [SRAM_AW-1:0]   req_base;
  logic [DATA_W-1:0]    wsh;
  logic [DATA_W-1:0]    rbuf;
  logic [DATA_W-1:0]    rd_next;
  logic [SRAM_DW-1:0]   dq_out;
  logic [SRAM_DW-1:0]   dq_in;
  logic                 dq_oe;
  logic                 req;
  logic                 beat_end;
  logic                 last_beat;

  assign req       = wr_en | rd_en;
  assign beat_end  = (cnt == NCNT_W'(WAIT_CYCLES - 1));
  assign last_beat = (beat == NBEAT_W'(NBEATS - 1));
  assign req_base  = SRAM_AW'(((addr - BASE_U) >> BYTE_SH) * BEATS_U);
  // Beats arrive low slice first, so each capture shifts in from the top;
  // after the last beat, beat 0 sits in the low slice.
  assign rd_next   = DATA_W'({dq_in, rbuf} >> SRAM_DW);
  assign freeze    = (state == IDLE) ? req : (state == ACCESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      cnt       <= '0;
      op_wr     <= 1'b0;
      base_q    <= '0;
      rbuf      <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      dq_oe     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= ACCESS;
            op_wr     <= wr_en;
            beat      <= '0;
            cnt       <= '0;
            base_q    <= req_base;
            SRAM_ADDR <= req_base;
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            SRAM_WE_N <= ~wr_en;
            SRAM_OE_N <= wr_en;
            dq_oe     <= wr_en;
          end
        end
        ACCESS: begin
          if (!op_wr && beat_end) rbuf <= rd_next;
          if (!beat_end) begin
            cnt <= cnt + 1'b1;
          end else if (last_beat) begin
            state     <= DONE;
            ready     <= 1'b1;
            dq_oe     <= 1'b0;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            if (!op_wr) rdata <= rd_next;
          end else begin
            beat      <= beat + 1'b1;
            cnt       <= '0;
            SRAM_ADDR <= base_q + SRAM_AW'(beat) + SRAM_AW'(1);
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store data path: pure datapath, only meaningful while dq_oe is set.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      dq_out <= wdata[SRAM_DW-1:0];
      wsh    <= wdata >> SRAM_DW;
    end else if (state == ACCESS && beat_end && !last_beat) begin
      dq_out <= wsh[SRAM_DW-1:0];
      wsh    <= wsh >> SRAM_DW;
    end
  end

  sram_dq_io #(.W(SRAM_DW)) u_dq_io (
    .dq   (SRAM_DQ),
    .oe   (dq_oe),
    .dout (dq_out),
    .din  (dq_in)
  );

endmodule

// File: tb/tb_sram_ctrl_param.sv
module tb_sram_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, wr_en, rd_en, preload;
  logic [31:0] addr;
  logic [63:0] wdata;
  wire         wr_a = wr_en & ~sel, rd_a = rd_en & ~sel;
  wire         wr_b = wr_en & sel,  rd_b = rd_en & sel;

  logic [31:0] rdata_a;
  logic [63:0] rdata_b;
  logic        ready_a, freeze_a, ub_a, lb_a, we_a, ce_a, oe_a;
  logic        ready_b, freeze_b, ub_b, lb_b, we_b, ce_b, oe_b;
  logic [17:0] sa_a, sa_b;
  wire  [15:0] dq_a, dq_b;

  sram_ctrl_param u_dut (
    .clk(clk), .rst(rst_n), .wr_en(wr_a), .rd_en(rd_a), .addr(addr), .wdata(wdata[31:0]),
    .rdata(rdata_a), .ready(ready_a), .freeze(freeze_a), .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a),
    .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_WE_N(we_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a));

  sram_ctrl_param #(.DATA_W(64), .WAIT_CYCLES(1)) u_dut64 (
    .clk(clk), .rst(rst_n), .wr_en(wr_b), .rd_en(rd_b), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ready(ready_b), .freeze(freeze_b), .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b),
    .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_WE_N(we_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b));

  // Reference contents per CPU word, and SRAM pin models holding 16-bit words.
  logic [31:0] ref_a [0:255];
  logic [63:0] ref_b [0:255];
  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];

  // The bus floats to 16'h5A5A whenever the chip is deselected, so a stray
  // drive from the controller shows up as a different value.
  assign dq_a = (!ce_a && !oe_a && we_a) ? mem_a[sa_a[9:0]] : (ce_a ? 16'h5A5A : 16'hzzzz);
  assign dq_b = (!ce_b && !oe_b && we_b) ? mem_b[sa_b[9:0]] : (ce_b ? 16'h5A5A : 16'hzzzz);

  always @(posedge clk) begin
    if (preload) begin
      for (int w = 0; w < 256; w++) begin
        mem_a[2*w]   <= ref_a[w][15:0];
        mem_a[2*w+1] <= ref_a[w][31:16];
        for (int k = 0; k < 4; k++) mem_b[4*w+k] <= ref_b[w][16*k +: 16];
      end
    end else begin
      if (!ce_a && !we_a) mem_a[sa_a[9:0]] <= dq_a;
      if (!ce_b && !we_b) mem_b[sa_b[9:0]] <= dq_b;
    end
  end

  wire        s_ce    = sel ? ce_b : ce_a;
  wire        s_we    = sel ? we_b : we_a;
  wire        s_oe    = sel ? oe_b : oe_a;
  wire        s_lane  = sel ? (ub_b | lb_b) : (ub_a | lb_a);
  wire        s_ready = sel ? ready_b : ready_a;
  wire        s_frz   = sel ? freeze_b : freeze_a;
  wire [17:0] s_addr  = sel ? sa_b : sa_a;
  wire [15:0] s_dq    = sel ? dq_b : dq_a;
  wire [63:0] s_rdata = sel ? rdata_b : {32'h0, rdata_a};

  int errors = 0;
  int checks = 0;
  logic [31:0] last_a = 32'h0;
  logic [63:0] last_b = 64'h0;

  int          r_frz, r_we, r_oe, r_lane, r_early;
  bit          r_tmo, r_dfrz, r_pfrz, r_prdy;
  logic [15:0] r_pdq;
  logic [63:0] r_done;
  logic [17:0] tr_addr[$];
  logic [15:0] tr_dq[$];

  // Drives one request and records what the pins and outputs did.
  task automatic run_op(input bit s, input bit w, input bit r, input logic [31:0] a,
                        input logic [63:0] d, input int drop);
    logic [63:0] rd_prev;
    sel = s; r_frz = 0; r_we = 0; r_oe = 0; r_lane = 0; r_early = 0; r_tmo = 1'b1;
    r_dfrz = 1'b1; r_pfrz = 1'b1; r_prdy = 1'b1; r_pdq = 16'h0; r_done = '0;
    tr_addr.delete(); tr_dq.delete();
    @(negedge clk);
    addr = a; wdata = d; wr_en = w; rd_en = r;
    #1;
    rd_prev = s_rdata;
    if (s_frz) r_frz++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == drop) begin wr_en = 1'b0; rd_en = 1'b0; end
      @(negedge clk);
      if (!s_ce) begin
        tr_addr.push_back(s_addr); tr_dq.push_back(s_dq);
        if (!s_we) r_we++;
        if (!s_oe) r_oe++;
        if (s_lane) r_lane++;
      end
      if (s_ready) begin
        r_done = s_rdata; r_dfrz = s_frz; r_tmo = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        r_pfrz = s_frz; r_prdy = s_ready; r_pdq = s_dq;
        break;
      end
      if (s_frz) r_frz++;
      if (s_rdata !== rd_prev) r_early++;
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 256; w++) begin
      ref_a[w] = $urandom;
      ref_b[w] = {$urandom, $urandom};
    end
    rst_n = 1'b0; sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; preload = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({ce_a, we_a, oe_a, ub_a, lb_a} !== 5'b11111) begin errors++; $display("FAIL reset_ctl got=%b want=11111", {ce_a, we_a, oe_a, ub_a, lb_a}); end
    checks++; if (sa_a !== 18'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", sa_a); end
    checks++; if (ready_a !== 1'b0 || freeze_a !== 1'b0) begin errors++; $display("FAIL reset_rdy_frz got=%b%b want=00", ready_a, freeze_a); end
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata_a); end
    checks++; if (dq_a !== 16'h5A5A) begin errors++; $display("FAIL reset_dq_float got=%h want=5a5a", dq_a); end
    checks++; if ({ce_b, we_b, oe_b} !== 3'b111 || rdata_b !== 64'h0) begin errors++; $display("FAIL reset_dut64 ctl=%b rdata=%h", {ce_b, we_b, oe_b}, rdata_b); end
    preload = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    run_op(0, 1, 0, 32'd1028, 64'hDEADBEEF, 0);
    checks++; if (r_tmo) begin errors++; $display("FAIL store_timeout got=no_ready want=ready"); end
    checks++; if (r_frz !== 7) begin errors++; $display("FAIL store_freeze got=%0d want=7", r_frz); end
    checks++; if (r_we !== 6 || r_oe !== 0 || r_lane !== 0) begin errors++; $display("FAIL store_ctl we=%0d oe=%0d lane=%0d want 6/0/0", r_we, r_oe, r_lane); end
    checks++; if (tr_addr.size() !== 6) begin errors++; $display("FAIL store_beats got=%0d want=6", tr_addr.size()); end
    for (int j = 0; j < tr_addr.size(); j++) begin
      checks++;
      if (int'(tr_addr[j]) !== 2 + j / 3 || tr_dq[j] !== ((j < 3) ? 16'hBEEF : 16'hDEAD)) begin
        errors++; $display("FAIL store_beat%0d got=%h/%h want=%0d/%h", j, tr_addr[j], tr_dq[j], 2 + j / 3, (j < 3) ? 16'hBEEF : 16'hDEAD);
      end
    end
    checks++; if (r_dfrz !== 1'b0 || r_prdy !== 1'b0 || r_pfrz !== 1'b0) begin errors++; $display("FAIL store_done dfrz=%b prdy=%b pfrz=%b want 000", r_dfrz, r_prdy, r_pfrz); end
    checks++; if (r_pdq !== 16'h5A5A) begin errors++; $display("FAIL store_idle_dq got=%h want=5a5a", r_pdq); end
    ref_a[1] = 32'hDEADBEEF;
  endtask

  task automatic test_load();
    run_op(0, 0, 1, 32'd1028, 64'h0, 0);
    checks++; if (r_tmo) begin errors++; $display("FAIL load_timeout got=no_ready want=ready"); end
    checks++; if (r_done[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%h want=deadbeef", r_done[31:0]); end
    checks++; if (r_oe !== 6 || r_we !== 0) begin errors++; $display("FAIL load_ctl oe=%0d we=%0d want 6/0", r_oe, r_we); end
    checks++; if (r_early !== 0) begin errors++; $display("FAIL load_partial got=%0d want=0", r_early); end
    checks++; if (r_frz !== 7 || r_prdy !== 1'b0) begin errors++; $display("FAIL load_frz_rdy frz=%0d prdy=%b want 7/0", r_frz, r_prdy); end
    last_a = 32'hDEADBEEF;
  endtask

  task automatic test_both();
    logic [31:0] d;
    d = $urandom;
    run_op(0, 1, 1, 32'd1032, {32'h0, d}, 0);
    checks++; if (r_we !== 6 || r_oe !== 0) begin errors++; $display("FAIL both_is_write we=%0d oe=%0d want 6/0", r_we, r_oe); end
    checks++; if (r_done[31:0] !== last_a) begin errors++; $display("FAIL both_rdata got=%h want=%h", r_done[31:0], last_a); end
    for (int j = 0; j < tr_addr.size(); j++) begin
      checks++;
      if (int'(tr_addr[j]) !== 4 + j / 3 || tr_dq[j] !== d[16*(j/3) +: 16]) begin
        errors++; $display("FAIL both_beat%0d got=%h/%h want=%0d/%h", j, tr_addr[j], tr_dq[j], 4 + j / 3, d[16*(j/3) +: 16]);
      end
    end
    ref_a[2] = d;
  endtask

  task automatic test_drop();
    run_op(0, 0, 1, 32'd1032, 64'h0, 1);
    checks++; if (r_tmo || tr_addr.size() !== 6) begin errors++; $display("FAIL drop_rd_beats got=%0d want=6", tr_addr.size()); end
    checks++; if (r_done[31:0] !== ref_a[2]) begin errors++; $display("FAIL drop_rd_rdata got=%h want=%h", r_done[31:0], ref_a[2]); end
    checks++; if (r_frz !== 7 || r_pfrz !== 1'b0) begin errors++; $display("FAIL drop_rd_freeze frz=%0d idle=%b want 7/0", r_frz, r_pfrz); end
    last_a = ref_a[2];
    run_op(0, 1, 0, 32'd1036, 64'h0000_0000_1357_9BDF, 1);
    checks++; if (r_we !== 6 || r_pfrz !== 1'b0) begin errors++; $display("FAIL drop_wr we=%0d idle=%b want 6/0", r_we, r_pfrz); end
    ref_a[3] = 32'h1357_9BDF;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int w;
      bit wr;
      logic [31:0] d;
      w = $urandom_range(0, 255); wr = ($urandom_range(0, 1) == 1); d = $urandom;
      run_op(0, wr, !wr, 32'd1024 + 32'(4 * w), {32'h0, d}, $urandom_range(0, 3));
      checks++; if (r_tmo || r_frz !== 7 || tr_addr.size() !== 6) begin errors++; $display("FAIL rnd%0d_shape tmo=%b frz=%0d beats=%0d", n, r_tmo, r_frz, tr_addr.size()); end
      for (int j = 0; j < tr_addr.size(); j++) begin
        checks++;
        if (int'(tr_addr[j]) !== 2 * w + j / 3 || (wr && tr_dq[j] !== d[16*(j/3) +: 16])) begin
          errors++; $display("FAIL rnd%0d_beat%0d got=%h/%h want=%0d/%h", n, j, tr_addr[j], tr_dq[j], 2 * w + j / 3, d[16*(j/3) +: 16]);
        end
      end
      if (wr) begin
        ref_a[w] = d;
        checks++; if (r_done[31:0] !== last_a) begin errors++; $display("FAIL rnd%0d_wr_rdata got=%h want=%h", n, r_done[31:0], last_a); end
      end else begin
        checks++; if (r_done[31:0] !== ref_a[w] || r_early !== 0) begin errors++; $display("FAIL rnd%0d_rd got=%h want=%h early=%0d", n, r_done[31:0], ref_a[w], r_early); end
        last_a = ref_a[w];
      end
    end
  endtask

  task automatic test_wide();
    logic [63:0] v;
    int w;
    v = 64'h0123456789ABCDEF;
    run_op(1, 1, 0, 32'd1024, v, 0);
    checks++; if (r_tmo || r_frz !== 5) begin errors++; $display("FAIL wide_freeze got=%0d want=5", r_frz); end
    checks++; if (r_we !== 4 || tr_addr.size() !== 4) begin errors++; $display("FAIL wide_beats we=%0d beats=%0d want 4/4", r_we, tr_addr.size()); end
    for (int j = 0; j < tr_addr.size(); j++) begin
      checks++;
      if (int'(tr_addr[j]) !== j || tr_dq[j] !== v[16*j +: 16]) begin
        errors++; $display("FAIL wide_beat%0d got=%h/%h want=%0d/%h", j, tr_addr[j], tr_dq[j], j, v[16*j +: 16]);
      end
    end
    ref_b[0] = v;
    run_op(1, 0, 1, 32'd1024, 64'h0, 0);
    checks++; if (r_done !== v || r_oe !== 4) begin errors++; $display("FAIL wide_load got=%h oe=%0d want=%h/4", r_done, r_oe, v); end
    w = $urandom_range(1, 255);
    run_op(1, 0, 1, 32'd1024 + 32'(8 * w), 64'h0, 0);
    checks++; if (r_done !== ref_b[w] || r_early !== 0) begin errors++; $display("FAIL wide_rnd_load got=%h want=%h", r_done, ref_b[w]); end
    for (int j = 0; j < tr_addr.size(); j++) begin
      checks++;
      if (int'(tr_addr[j]) !== 4 * w + j) begin errors++; $display("FAIL wide_rnd_addr%0d got=%0d want=%0d", j, tr_addr[j], 4 * w + j); end
    end
    last_b = ref_b[w];
  endtask

  task automatic test_reset_mid();
    run_op(0, 0, 1, 32'd1028, 64'h0, 0);
    last_a = ref_a[1];
    sel = 1'b0;
    @(negedge clk);
    addr = 32'd1024; wdata = {$urandom, $urandom}; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (we_a !== 1'b0 || ce_a !== 1'b0) begin errors++; $display("FAIL mid_in_access we=%b ce=%b want 0/0", we_a, ce_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ce_a !== 1'b1 || we_a !== 1'b1) begin errors++; $display("FAIL mid_async ce=%b we=%b want 1/1", ce_a, we_a); end
    @(negedge clk);
    checks++; if (ce_a !== 1'b1 || we_a !== 1'b1 || oe_a !== 1'b1) begin errors++; $display("FAIL mid_ctl got=%b want=111", {ce_a, we_a, oe_a}); end
    checks++; if (dq_a !== 16'h5A5A) begin errors++; $display("FAIL mid_dq_float got=%h want=5a5a", dq_a); end
    checks++; if (ready_a !== 1'b0 || rdata_a !== 32'h0 || sa_a !== 18'h0) begin errors++; $display("FAIL mid_outputs rdy=%b rdata=%h addr=%h want 0/0/0", ready_a, rdata_a, sa_a); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_both();
    test_drop();
    test_random();
    test_wide();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_ctrl_param.md
Name: sram_ctrl_param

Overview:
Parametrised SRAM controller serving the pipeline's memory stage. Converts one DATA_W-bit load/store into DATA_W/SRAM_DW sequential off-chip SRAM beats with a configurable number of wait cycles per beat. Stalls the pipeline through freeze until the access completes. Successor to the fixed 32-bit-over-16-bit memory-stage SRAM path: width, wait states and base address are all parameters.

Parameters:
DATA_W, 32, pipeline data word width; must be a multiple of SRAM_DW
SRAM_DW, 16, SRAM data bus width
SRAM_AW, 18, SRAM address width
WAIT_CYCLES, 3, cycles each beat is held on the pins; must be >= 1
BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  store request from memory stage
rd_en  in  1  load request from memory stage
addr  in  32  CPU byte address (ALU result)
wdata  in  DATA_W  store data (Rm value)
rdata  out  DATA_W  assembled load data
ready  out  1  one-cycle pulse; access complete
freeze  out  1  pipeline stall request
SRAM_DQ  inout  SRAM_DW  SRAM data bus
SRAM_ADDR  out  SRAM_AW  SRAM word address
SRAM_UB_N, SRAM_LB_N  out  1 each  byte-lane enables, active-low
SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  write, chip and output enables, active-low

Behaviour:
- BEATS = DATA_W/SRAM_DW. Word index = (addr - BASE_ADDR) >> log2(DATA_W/8). SRAM_ADDR = word_index*BEATS + beat, truncated to SRAM_AW. Beat 0 carries bits [SRAM_DW-1:0], so data is stored little-endian.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if wr_en or rd_en is high, latch addr, wdata and the op (write wins if both are high), clear beat and cycle counters, go to ACCESS. freeze = 1 in this cycle.
- ACCESS: CE_N, UB_N and LB_N are low.
  - Write: WE_N = 0, OE_N = 1, and DQ is driven with the current beat slice.
  - Read: WE_N = 1, OE_N = 0, and DQ is high-Z.
  - The cycle counter runs 0..WAIT_CYCLES-1.
  - On the last cycle of a read beat, capture DQ into the beat slice of rdata.
  - At the end of the last beat, go to DONE. Otherwise increment the beat and clear the counter.
  - freeze = 1 throughout.
- DONE: ready = 1 and freeze = 0 for exactly one cycle; SRAM is deselected (CE_N = 1); next state is IDLE.
- freeze = (rd_en | wr_en) in IDLE, 1 in ACCESS, 0 in DONE. Total stall = 1 + BEATS*WAIT_CYCLES cycles; default is 7.
- Outside ACCESS: CE_N, WE_N, OE_N, UB_N and LB_N are all 1, DQ is high-Z, and SRAM_ADDR holds its last value.
- Requests deasserted mid-access do not abort; the access completes on the latched values.
- rdata holds the last load value until the next load completes; partially loaded beats are never exposed before DONE.
- Reset (rst low, any state, asynchronous): state IDLE, counters 0, rdata 0, ready 0, SRAM_ADDR 0, all SRAM controls 1, DQ high-Z. freeze then follows the IDLE rule. An aborted write leaves SRAM contents undefined at that word.
- Parameter violations (DATA_W % SRAM_DW != 0, WAIT_CYCLES < 1) are a fatal elaboration error.

Decomposition:
- Package sram_ctrl_pkg: state enum (IDLE/ACCESS/DONE), helper function clog2, derived constants BEATS, BEAT_W and CNT_W.
- Sub-module sram_dq_io: tristate driver. Inputs are drive enable and out data; it presents DQ in-data.
- The FSM, counters and data assembly stay in sram_ctrl_param.

Test Plan:
- Reset mid-ACCESS of a write to addr 1024 -> next cycle CE_N = WE_N = 1, DQ = Z, ready = 0, rdata = 0.
- Store wdata 0xDEADBEEF to addr 1028 (defaults) -> SRAM_ADDR 2 then 3, DQ 0xBEEF then 0xDEAD, each with WE_N low for 3 cycles. freeze high 7 cycles, then ready pulse.
- Load from addr 1028 with an SRAM model holding that word -> rdata = 0xDEADBEEF in the DONE cycle, ready for 1 cycle, OE_N low for 6 cycles.
- DATA_W = 64, WAIT_CYCLES = 1: store 0x0123456789ABCDEF at addr 1024 -> 4 beats at SRAM_ADDR 0..3 (0xCDEF, 0x89AB, 0x4567, 0x0123); freeze high 5 cycles.
- rd_en and wr_en both high at addr 1032 -> write performed (WE_N low), no rdata update.
- Request dropped one cycle after acceptance -> access still completes all beats and pulses ready; the following IDLE with no request gives freeze = 0.
